// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// dsp_mac_sequencer
// Drives one DSP slice as a dot-product engine and returns P over valid/ready.
// Revision: 1.0
// ============================================================================
module dsp_mac_sequencer #(
  parameter int LEN_W    = 10,
  parameter int PIPE_LAT = 2,
  parameter int P_LAT    = 1
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [LEN_W-1:0] start_len,
  input  logic             start_sub,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic             busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  // Tag stage 0 rides alongside the dsp_a/dsp_b register; PIPE_LAT more stages reach M.
  localparam int TAG_W  = PIPE_LAT + 1;
  localparam int WAIT_W = (P_LAT > 1) ? $clog2(P_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(P_LAT - 1);

  logic [1:0]        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issue;
  logic [LEN_W-1:0]  r_acc;
  logic              r_sub;
  logic [TAG_W-1:0]  r_tag;
  logic [WAIT_W-1:0] r_wait;
  logic [17:0]       r_dsp_a;
  logic [17:0]       r_dsp_b;
  logic [47:0]       r_res_data;

  logic w_start_fire;
  logic w_in_fire;
  logic w_cep;
  logic w_issue_last;

  assign start_ready  = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign in_ready     = (r_state == S_STREAM) && (r_issue < r_len);
  assign res_valid    = (r_state == S_RESULT);
  assign res_data     = r_res_data;
  assign w_start_fire = start_valid && start_ready;
  assign w_in_fire    = in_valid && in_ready;
  assign w_cep        = r_tag[TAG_W-1];
  assign w_issue_last = ((r_issue + LEN_W'(1)) == r_len);

  assign dsp_a   = r_dsp_a;
  assign dsp_b   = r_dsp_b;
  assign dsp_cea = 1'b1;
  assign dsp_ceb = 1'b1;
  assign dsp_cem = 1'b1;
  assign dsp_cep = w_cep;

  // Z=0 on the job's first product discards whatever stale value P holds.
  assign dsp_opmode = w_cep ? {r_sub, 3'b000, (r_acc == '0) ? 2'b00 : 2'b10, 2'b01} : 8'h00;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_tag   <= '0;
      r_dsp_a <= '0;
      r_dsp_b <= '0;
      r_acc   <= '0;
    end else begin
      r_tag   <= {r_tag[TAG_W-2:0], w_in_fire};
      r_dsp_a <= w_in_fire ? in_a : 18'd0;
      r_dsp_b <= w_in_fire ? in_b : 18'd0;
      if (w_start_fire) begin
        r_acc <= '0;
      end else if (w_cep) begin
        r_acc <= r_acc + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_sub      <= 1'b0;
      r_issue    <= '0;
      r_wait     <= '0;
      r_res_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_fire) begin
            r_len   <= start_len;
            r_sub   <= start_sub;
            r_issue <= '0;
            r_wait  <= '0;
            if (start_len == '0) begin
              r_res_data <= '0;
              r_state    <= S_RESULT;
            end else begin
              r_state <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (w_in_fire) begin
            r_issue <= r_issue + LEN_W'(1);
            if (w_issue_last) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (r_acc == r_len) begin
            if (r_wait == WAIT_LAST) begin
              r_res_data <= dsp_p;
              r_state    <= S_RESULT;
            end else begin
              r_wait <= r_wait + WAIT_W'(1);
            end
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`default_nettype none
// Testbench for dsp_mac_sequencer: behavioural DSP slice plus a sum-of-products reference.
module tb_dsp_mac_sequencer;
  localparam int LEN_W    = 10;
  localparam int PIPE_LAT = 2;
  localparam int P_LAT    = 1;

  logic             CLK = 1'b0;
  logic             rst_n = 1'b1;
  logic             start_valid = 1'b0;
  logic [LEN_W-1:0] start_len = '0;
  logic             start_sub = 1'b0;
  logic             in_valid = 1'b0;
  logic [17:0]      in_a = '0;
  logic [17:0]      in_b = '0;
  logic             res_ready = 1'b1;
  logic             start_ready, in_ready, dsp_cea, dsp_ceb, dsp_cem, dsp_cep, res_valid, busy;
  logic [17:0]      dsp_a, dsp_b;
  logic [7:0]       dsp_opmode;
  logic [47:0]      dsp_p, res_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [17:0] ga [0:63];
  logic [17:0] gb [0:63];
  logic [7:0]  op_q [$];

  dsp_mac_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT), .P_LAT(P_LAT)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready), .start_len(start_len), .start_sub(start_sub),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem), .dsp_cep(dsp_cep),
    .dsp_p(dsp_p), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // DSP slice model: A1/B1 register, M register, P = Z +/- X under OPMODE; P is never reset.
  logic [17:0] s_a1 = '0, s_b1 = '0;
  logic [47:0] s_m = '0, s_p = 48'h0000_5A5A_1234;
  logic [47:0] s_z, s_x;
  assign s_z   = (dsp_opmode[3:2] == 2'b10) ? s_p : 48'd0;
  assign s_x   = (dsp_opmode[1:0] == 2'b01) ? s_m : 48'd0;
  assign dsp_p = s_p;
  always @(posedge CLK) begin
    if (dsp_cea) s_a1 <= dsp_a;
    if (dsp_ceb) s_b1 <= dsp_b;
    if (dsp_cem) s_m <= 48'(s_a1) * 48'(s_b1);
    if (dsp_cep) s_p <= dsp_opmode[7] ? (s_z - s_x) : (s_z + s_x);
  end

  always @(negedge CLK) if (rst_n && dsp_cep) op_q.push_back(dsp_opmode);

  function automatic logic [47:0] ref_dot(input int n, input bit sub);
    logic [47:0] acc = '0;
    for (int i = 0; i < n; i++) acc += 48'(ga[i]) * 48'(gb[i]);
    return sub ? (48'd0 - acc) : acc;
  endfunction

  function automatic logic [7:0] ref_op(input bit sub, input int idx);
    return (sub ? 8'h80 : 8'h00) | ((idx == 0) ? 8'h01 : 8'h09);
  endfunction

  task automatic apply_reset();
    @(negedge CLK);
    rst_n = 1'b0; start_valid = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic start_job(input int n, input bit sub, output int scyc);
    op_q.delete();
    start_len = LEN_W'(n); start_sub = sub; start_valid = 1'b1;
    scyc = cyc;
    @(negedge CLK);
    start_valid = 1'b0;
  endtask

  task automatic stream(input int n, input int gap, input bit rnd_gap, output int hs0, output bit ok);
    ok = 1'b1; hs0 = -1;
    for (int i = 0; i < n; i++) begin
      int g;
      int t;
      g = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
      if (i > 0) repeat (g) @(negedge CLK);
      in_valid = 1'b1; in_a = ga[i]; in_b = gb[i];
      t = 0;
      while (!in_ready && t < 50) begin @(negedge CLK); t++; end
      if (!in_ready) begin ok = 1'b0; in_valid = 1'b0; return; end
      if (i == 0) hs0 = cyc;
      @(negedge CLK);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_res(output int rcyc, output bit ok);
    int t = 0;
    while (!res_valid && t < 300) begin @(negedge CLK); t++; end
    ok = res_valid; rcyc = cyc;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    rst_n = 1'b0;
    #1;
    checks++; if (dsp_a !== 18'd0) begin errors++; $display("FAIL reset_dsp_a: got %0h want 0", dsp_a); end
    checks++; if (dsp_b !== 18'd0) begin errors++; $display("FAIL reset_dsp_b: got %0h want 0", dsp_b); end
    checks++; if (dsp_opmode !== 8'h00) begin errors++; $display("FAIL reset_opmode: got %0h want 0", dsp_opmode); end
    checks++; if (dsp_cep !== 1'b0) begin errors++; $display("FAIL reset_cep: got %0b want 0", dsp_cep); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
    checks++; if (res_data !== 48'd0) begin errors++; $display("FAIL reset_res_data: got %0h want 0", res_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got %0b want 1", start_ready); end
    checks++; if ({dsp_cea, dsp_ceb, dsp_cem} !== 3'b111) begin errors++; $display("FAIL reset_ce: got %0b want 111", {dsp_cea, dsp_ceb, dsp_cem}); end
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_add();
    int s, hs, r; bit ok, okr;
    apply_reset();
    ga[0] = 18'd2; gb[0] = 18'd3; ga[1] = 18'd4; gb[1] = 18'd5; ga[2] = 18'd1; gb[2] = 18'd6;
    start_job(3, 1'b0, s);
    stream(3, 0, 1'b0, hs, ok);
    checks++; if (!ok) begin errors++; $display("FAIL add_stream_timeout: got stall want accept"); end
    wait_res(r, okr);
    checks++; if (!okr) begin errors++; $display("FAIL add_res_timeout: got no res_valid want res_valid"); end
    checks++; if (res_data !== ref_dot(3, 1'b0)) begin errors++; $display("FAIL add_result: got %0h want %0h", res_data, ref_dot(3, 1'b0)); end
    checks++; if (r - hs != 3 + PIPE_LAT + P_LAT + 1) begin errors++; $display("FAIL add_latency: got %0d want %0d", r - hs, 3 + PIPE_LAT + P_LAT + 1); end
    checks++; if (start_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL add_busy_in_result: got sr=%0b busy=%0b want 0/1", start_ready, busy); end
    checks++; if (op_q.size() != 3) begin errors++; $display("FAIL add_cep_count: got %0d want 3", op_q.size()); end
    for (int i = 0; i < op_q.size() && i < 3; i++) begin
      checks++; if (op_q[i] !== ref_op(1'b0, i)) begin errors++; $display("FAIL add_opmode[%0d]: got %0h want %0h", i, op_q[i], ref_op(1'b0, i)); end
    end
    @(negedge CLK);
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_after_accept: got rv=%0b busy=%0b want 0/0", res_valid, busy); end
  endtask

  task automatic test_sub();
    int s, hs, r; bit ok, okr;
    apply_reset();
    ga[0] = 18'd3; gb[0] = 18'd3; ga[1] = 18'd1; gb[1] = 18'd1;
    start_job(2, 1'b1, s);
    stream(2, 0, 1'b0, hs, ok);
    wait_res(r, okr);
    checks++; if (!ok || !okr) begin errors++; $display("FAIL sub_timeout: got stream=%0b res=%0b want 1/1", ok, okr); end
    checks++; if (res_data !== ref_dot(2, 1'b1)) begin errors++; $display("FAIL sub_result: got %0h want %0h", res_data, ref_dot(2, 1'b1)); end
    checks++; if (op_q.size() != 2) begin errors++; $display("FAIL sub_cep_count: got %0d want 2", op_q.size()); end
    for (int i = 0; i < op_q.size() && i < 2; i++) begin
      checks++; if (op_q[i] !== ref_op(1'b1, i)) begin errors++; $display("FAIL sub_opmode[%0d]: got %0h want %0h", i, op_q[i], ref_op(1'b1, i)); end
    end
    @(negedge CLK);
  endtask

  task automatic test_bubbles();
    int s, hs, r; bit ok, okr;
    apply_reset();
    for (int i = 0; i < 3; i++) begin ga[i] = 18'(i + 1); gb[i] = 18'(i + 1); end
    start_job(3, 1'b0, s);
    stream(3, 2, 1'b0, hs, ok);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bub_in_ready_drop: got %0b want 0", in_ready); end
    wait_res(r, okr);
    checks++; if (!ok || !okr) begin errors++; $display("FAIL bub_timeout: got stream=%0b res=%0b want 1/1", ok, okr); end
    checks++; if (res_data !== ref_dot(3, 1'b0)) begin errors++; $display("FAIL bub_result: got %0h want %0h", res_data, ref_dot(3, 1'b0)); end
    checks++; if (op_q.size() != 3) begin errors++; $display("FAIL bub_cep_count: got %0d want 3", op_q.size()); end
    @(negedge CLK);
  endtask

  task automatic test_zero_len();
    int s;
    apply_reset();
    start_job(0, 1'b0, s);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL zero_res_valid: got %0b want 1 (%0d cycles)", res_valid, cyc - s); end
    checks++; if (res_data !== 48'd0) begin errors++; $display("FAIL zero_res_data: got %0h want 0", res_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_in_ready: got %0b want 0", in_ready); end
    @(negedge CLK);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL zero_after_accept: got %0b want 0", res_valid); end
    repeat (4) @(negedge CLK);
    checks++; if (op_q.size() != 0) begin errors++; $display("FAIL zero_cep_count: got %0d want 0", op_q.size()); end
  endtask

  task automatic test_backpressure();
    int s, hs, r; bit ok, okr; logic [47:0] exp;
    apply_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin ga[i] = 18'($urandom_range(18'h3FFFF, 1)); gb[i] = 18'($urandom_range(18'h3FFFF, 1)); end
    exp = ref_dot(3, 1'b0);
    start_job(3, 1'b0, s);
    stream(3, 0, 1'b0, hs, ok);
    wait_res(r, okr);
    checks++; if (!ok || !okr) begin errors++; $display("FAIL bp_timeout: got stream=%0b res=%0b want 1/1", ok, okr); end
    for (int k = 0; k < 5; k++) begin
      start_valid = 1'b1; start_len = LEN_W'(5);
      @(negedge CLK);
      checks++; if (res_valid !== 1'b1 || res_data !== exp) begin errors++; $display("FAIL bp_hold[%0d]: got rv=%0b data=%0h want 1/%0h", k, res_valid, res_data, exp); end
      checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL bp_start_ready[%0d]: got %0b want 0", k, start_ready); end
    end
    start_valid = 1'b0; res_ready = 1'b1;
    @(negedge CLK);
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_after_accept: got rv=%0b busy=%0b want 0/0", res_valid, busy); end
    ga[0] = 18'd7; gb[0] = 18'd8;
    start_job(1, 1'b0, s);
    stream(1, 0, 1'b0, hs, ok);
    wait_res(r, okr);
    checks++; if (!ok || !okr) begin errors++; $display("FAIL bp2_timeout: got stream=%0b res=%0b want 1/1", ok, okr); end
    checks++; if (res_data !== ref_dot(1, 1'b0)) begin errors++; $display("FAIL bp2_result: got %0h want %0h", res_data, ref_dot(1, 1'b0)); end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int s, hs, r; bit ok, okr;
    apply_reset();
    for (int i = 0; i < 4; i++) begin ga[i] = 18'(i + 9); gb[i] = 18'(i + 3); end
    start_job(4, 1'b0, s);
    stream(2, 0, 1'b0, hs, ok);
    rst_n = 1'b0;
    #1;
    checks++; if (dsp_a !== 18'd0 || dsp_b !== 18'd0) begin errors++; $display("FAIL mid_dsp_ab: got %0h/%0h want 0/0", dsp_a, dsp_b); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_busy_in_ready: got %0b/%0b want 0/0", busy, in_ready); end
    checks++; if (dsp_cep !== 1'b0 || dsp_opmode !== 8'h00) begin errors++; $display("FAIL mid_cep_opmode: got %0b/%0h want 0/0", dsp_cep, dsp_opmode); end
    checks++; if (res_valid !== 1'b0 || res_data !== 48'd0) begin errors++; $display("FAIL mid_res: got %0b/%0h want 0/0", res_valid, res_data); end
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    ga[0] = 18'd1; gb[0] = 18'd2; ga[1] = 18'd3; gb[1] = 18'd4;
    start_job(2, 1'b0, s);
    stream(2, 0, 1'b0, hs, ok);
    wait_res(r, okr);
    checks++; if (!ok || !okr) begin errors++; $display("FAIL mid2_timeout: got stream=%0b res=%0b want 1/1", ok, okr); end
    checks++; if (res_data !== ref_dot(2, 1'b0)) begin errors++; $display("FAIL mid2_result: got %0h want %0h", res_data, ref_dot(2, 1'b0)); end
    @(negedge CLK);
  endtask

  task automatic test_random();
    int s, hs, r, n; bit ok, okr, sub;
    apply_reset();
    for (int j = 0; j < 8; j++) begin
      n = int'($urandom_range(12, 1));
      sub = 1'($urandom_range(1, 0));
      for (int i = 0; i < n; i++) begin ga[i] = 18'($urandom); gb[i] = 18'($urandom); end
      start_job(n, sub, s);
      stream(n, 2, 1'b1, hs, ok);
      wait_res(r, okr);
      checks++; if (!ok || !okr) begin errors++; $display("FAIL rnd%0d_timeout: got stream=%0b res=%0b want 1/1", j, ok, okr); end
      checks++; if (res_data !== ref_dot(n, sub)) begin errors++; $display("FAIL rnd%0d_result: got %0h want %0h", j, res_data, ref_dot(n, sub)); end
      checks++; if (op_q.size() != n) begin errors++; $display("FAIL rnd%0d_cep_count: got %0d want %0d", j, op_q.size(), n); end
      for (int i = 0; i < op_q.size() && i < n; i++) begin
        checks++; if (op_q[i] !== ref_op(sub, i)) begin errors++; $display("FAIL rnd%0d_opmode[%0d]: got %0h want %0h", j, i, op_q[i], ref_op(sub, i)); end
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_bubbles();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controller that drives one DSP slice instance as a dot-product engine: accepts a job (length, add/sub), streams operand pairs into the slice's A/B ports, and sequences OPMODE/CEP so products accumulate in P.
- Returns the 48-bit result over a valid/ready handshake.
- Sits between the operand-fetch logic and the DSP slice, and owns all of the slice's dynamic control inputs.

Parameters:
- LEN_W, 10, width of job length; maximum job is 2^LEN_W-1 terms.
- PIPE_LAT, 2, cycles from operands presented on dsp_a/dsp_b to product valid at the slice's M output (A1REG=1, MREG=1 build).
- P_LAT, 1, cycles from a CEP cycle to the updated value on dsp_p.

Ports:
- CLK  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  job request.
- start_ready  out  1  high only in IDLE.
- start_len  in  LEN_W  number of terms.
- start_sub  in  1  1: P = P - M accumulation; 0: P = P + M.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when both are high.
- in_a  in  18  operand A.
- in_b  in  18  operand B.
- dsp_a  out  18  to slice A.
- dsp_b  out  18  to slice B.
- dsp_opmode  out  8  to slice OPMODE.
- dsp_cea  out  1  to slice CEA.
- dsp_ceb  out  1  to slice CEB.
- dsp_cem  out  1  to slice CEM.
- dsp_cep  out  1  to slice CEP.
- dsp_p  in  48  from slice P.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_data  out  48  accumulated result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE; all counters and tag pipeline cleared.
  - Outputs: dsp_a=0, dsp_b=0, dsp_opmode=0, dsp_cep=0, res_valid=0, res_data=0, in_ready=0, busy=0.
  - dsp_cea=dsp_ceb=dsp_cem=1 at all times.
- States: IDLE, STREAM, DRAIN, RESULT.
- IDLE:
  - start_valid&&start_ready latches len and sub.
  - len=0: go straight to RESULT with res_data=0; the slice is not touched.
  - len>0: go to STREAM; issue count and accumulate count both cleared.
- STREAM:
  - in_ready = (issue count < len).
  - On handshake: dsp_a/dsp_b register in_a/in_b, a valid tag enters a PIPE_LAT-deep shift register, issue count increments.
  - No handshake: dsp_a/dsp_b load 0 and a zero tag enters.
  - When issue count reaches len, go to DRAIN (in_ready low from the cycle after the last handshake).
- Tag pipeline: the tag at the output stage marks the cycle where a valid product is on M.
  - In that cycle dsp_cep=1; otherwise dsp_cep=0.
  - dsp_opmode is combinational from the tag stage:
    - X=M (bits[1:0]=01).
    - Z=0 (bits[3:2]=00) for the first accumulated product of the job, else Z=P (10).
    - bit7=sub; bits[6:4]=0.
  - Resulting opmode values:
    - add: first 8'h01, then 8'h09.
    - sub: first 8'h81, then 8'h89.
  - Accumulate count increments on each dsp_cep cycle.
  - Bubbles in operand stream: no CEP, P holds.
- DRAIN:
  - Wait until accumulate count == len, then P_LAT further cycles.
  - res_data <= dsp_p; go to RESULT.
- RESULT:
  - res_valid=1; res_data stable until res_valid&&res_ready.
  - Then go to IDLE; res_valid drops the next cycle.
  - start_ready stays low until back in IDLE, so there is no overlap between jobs.
- Arithmetic: the slice's 18x18 product is treated as unsigned by the slice, as wired. Results are mod 2^48; no overflow flag. Test values are chosen non-negative.
- Latency, full back-to-back stream: first handshake to res_valid = len + PIPE_LAT + P_LAT + 1 cycles.
- Simultaneous events:
  - start_valid while busy: ignored (not consumed).
  - in_valid outside STREAM: ignored.
- Reset mid-job: all state discarded immediately. The slice's P is stale, but the next job's first product uses Z=0, so no clearing cycle is needed.

Test Plan:
- Add job: len=3, pairs (2,3),(4,5),(1,6) back-to-back, res_ready=1 -> res_data=32; dsp_opmode sequence 01,09,09 on the three CEP cycles; res_valid 7 cycles after first handshake.
- Sub job: start_sub=1, len=2, pairs (3,3),(1,1) -> res_data=48'hFFFF_FFFF_FFF6 (-10); opmodes 81,89.
- Bubbles: len=3, pairs (1,1),(2,2),(3,3) with in_valid low 2 cycles between each -> res_data=14; exactly 3 CEP pulses; in_ready drops after third handshake.
- Zero length: start_len=0 -> res_valid next cycle, res_data=0, zero dsp_cep pulses.
- Backpressure and overlap: res_ready low 5 cycles -> res_valid/res_data held, start_ready=0, start_valid ignored; after accept, a second job (len=1, (7,8)) -> 56, unaffected by prior P.
- Reset mid-STREAM after 2 of 4 handshakes -> all outputs at reset values immediately; a new job (len=2, (1,2),(3,4)) -> res_data=14.
